// File: rtl/par2serial_phy.sv
// par2serial_phy: byte-to-bit serializer for the PHY transmit path.
// Shifts one symbol out MSB first every 8 bit-clocks, substituting the COM
// idle symbol whenever no byte is offered and during the post-reset link-init
// window. active_out marks bits that belong to a data symbol, which is the
// only way to tell a data byte equal to IDLE_SYM from a genuine idle.
module par2serial_phy #(
    parameter logic [7:0]  IDLE_SYM     = 8'hBC,
    parameter int unsigned NUM_COM_INIT = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] in,
    input  logic       valid_in,
    output logic       ready_out,
    output logic       out,
    output logic       active_out
);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Value of init_cnt at the boundary that ends the init window.
    localparam logic [3:0] INIT_LAST = 4'(NUM_COM_INIT - 1);

    state_t     state_q, state_d;
    logic [7:0] sym_q, sym_d;
    logic [2:0] cnt_q, cnt_d;
    logic       sym_is_data_q, sym_is_data_d;
    logic [3:0] init_cnt_q, init_cnt_d;
    logic       out_q, out_d;
    logic       active_q, active_d;

    logic       boundary_s;
    logic       ready_s;

    // The last bit of the current symbol is shifted on this edge.
    assign boundary_s = (cnt_q == 3'd7);
    // A byte is only taken on the final bit of a symbol once the link is up,
    // so the next symbol follows the current one with no gap.
    assign ready_s    = (state_q == ST_RUN) && boundary_s;

    assign ready_out  = ready_s;
    assign out        = out_q;
    assign active_out = active_q;

    // Next-state logic: bit shifting, symbol reload at boundaries, init FSM.
    always_comb begin
        state_d       = state_q;
        sym_d         = sym_q;
        sym_is_data_d = sym_is_data_q;
        init_cnt_d    = init_cnt_q;
        out_d         = sym_q[3'd7 - cnt_q];
        active_d      = sym_is_data_q;
        cnt_d         = cnt_q + 3'd1;

        if (boundary_s) begin
            // in is only looked at when it is both offered and accepted,
            // so an undriven bus with valid_in=0 can never leak into sym.
            if (valid_in && ready_s) begin
                sym_d         = in;
                sym_is_data_d = 1'b1;
            end else begin
                sym_d         = IDLE_SYM;
                sym_is_data_d = 1'b0;
            end

            case (state_q)
                ST_INIT: begin
                    if (init_cnt_q == INIT_LAST) begin
                        state_d    = ST_RUN;
                        init_cnt_d = 4'd0;
                    end else begin
                        state_d    = ST_INIT;
                        init_cnt_d = init_cnt_q + 4'd1;
                    end
                end
                ST_RUN: begin
                    state_d    = ST_RUN;
                    init_cnt_d = 4'd0;
                end
                default: begin
                    state_d    = ST_INIT;
                    init_cnt_d = 4'd0;
                end
            endcase
        end else begin
            state_d    = state_q;
            init_cnt_d = init_cnt_q;
        end
    end

    // State and output registers; reset drops any partial symbol at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_INIT;
            sym_q         <= IDLE_SYM;
            cnt_q         <= 3'd0;
            sym_is_data_q <= 1'b0;
            init_cnt_q    <= 4'd0;
            out_q         <= 1'b0;
            active_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            sym_q         <= sym_d;
            cnt_q         <= cnt_d;
            sym_is_data_q <= sym_is_data_d;
            init_cnt_q    <= init_cnt_d;
            out_q         <= out_d;
            active_q      <= active_d;
        end
    end

endmodule
